// File: rtl/decode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_sequencer : instruction classify + 2-entry skid FIFO + halt/flush   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+

package op_pkg;
    typedef enum logic [3:0] {
        OPCODE_NOP   = 4'd0,
        OPCODE_ADD   = 4'd1,
        OPCODE_SUB   = 4'd2,
        OPCODE_LDUR  = 4'd3,
        OPCODE_STUR  = 4'd4,
        OPCODE_B     = 4'd5,
        OPCODE_BL    = 4'd6,
        OPCODE_CBZ   = 4'd7,
        OPCODE_HLT   = 4'd8,
        OPCODE_ERROR = 4'd9
    } opcode_t;

    // Instruction opcode lookup; any word not recognised is OPCODE_ERROR.
    function automatic opcode_t istable(input logic [31:0] insn);
        opcode_t op;
        op = OPCODE_ERROR;
        if (insn == 32'hD503_201F)                                    op = OPCODE_NOP;
        else if (insn[31:24] == 8'h91)                                op = OPCODE_ADD;
        else if (insn[31:24] == 8'h8B && !insn[21])                   op = OPCODE_ADD;
        else if (insn[31:24] == 8'hD1)                                op = OPCODE_SUB;
        else if (insn[31:24] == 8'hCB && !insn[21])                   op = OPCODE_SUB;
        else if (insn[31:21] == 11'h7C2 && insn[11:10] == 2'b00)      op = OPCODE_LDUR;
        else if (insn[31:21] == 11'h7C0 && insn[11:10] == 2'b00)      op = OPCODE_STUR;
        else if (insn[31:26] == 6'b000101)                            op = OPCODE_B;
        else if (insn[31:26] == 6'b100101)                            op = OPCODE_BL;
        else if (insn[31:24] == 8'hB4)                                op = OPCODE_CBZ;
        else if (insn[31:21] == 11'h6A2 && insn[4:0] == 5'd0)         op = OPCODE_HLT;
        return op;
    endfunction
endpackage

module decode_sequencer
    import op_pkg::*;
#(
    parameter int PC_WIDTH  = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_N_in,
    input  logic                 fetch_valid_in,
    output logic                 fetch_ready_out,
    input  logic [31:0]          fetch_insn_in,
    input  logic [PC_WIDTH-1:0]  fetch_pc_in,
    input  logic                 flush_in,
    output logic                 dec_valid_out,
    input  logic                 dec_ready_in,
    output opcode_t              dec_op_out,
    output logic [31:0]          dec_insn_out,
    output logic [PC_WIDTH-1:0]  dec_pc_out,
    output logic                 halted_out,
    output logic [CNT_WIDTH-1:0] decoded_count_out
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    opcode_t               op0_q, op0_d, op1_q, op1_d;
    logic [31:0]           insn0_q, insn0_d, insn1_q, insn1_d;
    logic [PC_WIDTH-1:0]   pc0_q, pc0_d, pc1_q, pc1_d;
    logic                  halt0_q, halt0_d, halt1_q, halt1_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    opcode_t new_op;
    logic    new_halt;
    logic    push;
    logic    pop;

    assign new_op          = istable(fetch_insn_in);
    assign new_halt        = (new_op == OPCODE_HLT) || (new_op == OPCODE_ERROR);
    assign fetch_ready_out = (state_q == ST_RUN) && (occ_q != 2'd2) && !flush_in;
    assign push            = fetch_valid_in && fetch_ready_out;
    assign pop             = (occ_q != 2'd0) && dec_ready_in;

    assign dec_valid_out     = (occ_q != 2'd0);
    assign dec_op_out        = op0_q;
    assign dec_insn_out      = insn0_q;
    assign dec_pc_out        = pc0_q;
    assign halted_out        = (state_q == ST_HALTED);
    assign decoded_count_out = count_q;

    // Slot 0 is always the head; slot 1 shifts down when the head leaves.
    always_comb begin
        occ_d   = occ_q;
        op0_d   = op0_q;
        insn0_d = insn0_q;
        pc0_d   = pc0_q;
        halt0_d = halt0_q;
        op1_d   = op1_q;
        insn1_d = insn1_q;
        pc1_d   = pc1_q;
        halt1_d = halt1_q;
        if (flush_in) begin
            occ_d   = 2'd0;
            halt0_d = 1'b0;
            halt1_d = 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    occ_d = occ_q + 2'd1;
                    if (occ_q == 2'd0) begin
                        op0_d   = new_op;
                        insn0_d = fetch_insn_in;
                        pc0_d   = fetch_pc_in;
                        halt0_d = new_halt;
                    end else begin
                        op1_d   = new_op;
                        insn1_d = fetch_insn_in;
                        pc1_d   = fetch_pc_in;
                        halt1_d = new_halt;
                    end
                end
                2'b01: begin
                    occ_d = occ_q - 2'd1;
                    if (occ_q == 2'd2) begin
                        op0_d   = op1_q;
                        insn0_d = insn1_q;
                        pc0_d   = pc1_q;
                        halt0_d = halt1_q;
                    end
                    halt1_d = 1'b0;
                end
                2'b11: begin
                    // Only reachable at occupancy 1: the new word replaces the head.
                    op0_d   = new_op;
                    insn0_d = fetch_insn_in;
                    pc0_d   = fetch_pc_in;
                    halt0_d = new_halt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (pop && !(&count_q)) begin
            count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        case (state_q)
            ST_RUN: begin
                if (push && new_halt) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (flush_in)             state_d = ST_RUN;
                else if (pop && halt0_q)  state_d = ST_HALTED;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q <= ST_RUN;
            occ_q   <= 2'd0;
            op0_q   <= OPCODE_NOP;
            insn0_q <= '0;
            pc0_q   <= '0;
            halt0_q <= 1'b0;
            op1_q   <= OPCODE_NOP;
            insn1_q <= '0;
            pc1_q   <= '0;
            halt1_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            op0_q   <= op0_d;
            insn0_q <= insn0_d;
            pc0_q   <= pc0_d;
            halt0_q <= halt0_d;
            op1_q   <= op1_d;
            insn1_q <= insn1_d;
            pc1_q   <= pc1_d;
            halt1_q <= halt1_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decode_sequencer : directed + randomized checks of decode_sequencer     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_decode_sequencer;
    import op_pkg::*;

    localparam int PCW = 64;
    localparam int CW  = 4;

    logic            clk_in = 1'b0;
    logic            rst_N_in;
    logic            fetch_valid_in;
    logic            fetch_ready_out;
    logic [31:0]     fetch_insn_in;
    logic [PCW-1:0]  fetch_pc_in;
    logic            flush_in;
    logic            dec_valid_out;
    logic            dec_ready_in;
    opcode_t         dec_op_out;
    logic [31:0]     dec_insn_out;
    logic [PCW-1:0]  dec_pc_out;
    logic            halted_out;
    logic [CW-1:0]   decoded_count_out;

    always #5 clk_in = ~clk_in;

    decode_sequencer #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) dut (
        .clk_in            (clk_in),
        .rst_N_in          (rst_N_in),
        .fetch_valid_in    (fetch_valid_in),
        .fetch_ready_out   (fetch_ready_out),
        .fetch_insn_in     (fetch_insn_in),
        .fetch_pc_in       (fetch_pc_in),
        .flush_in          (flush_in),
        .dec_valid_out     (dec_valid_out),
        .dec_ready_in      (dec_ready_in),
        .dec_op_out        (dec_op_out),
        .dec_insn_out      (dec_insn_out),
        .dec_pc_out        (dec_pc_out),
        .halted_out        (halted_out),
        .decoded_count_out (decoded_count_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of pending results plus two flags.
    typedef struct {
        opcode_t        op;
        logic [31:0]    insn;
        logic [PCW-1:0] pc;
        bit             halt;
    } entry_t;

    entry_t mq[$];
    bit     m_drain;
    bit     m_halted;
    int     m_count;

    logic [31:0] t_mask [11] = '{32'hFFFFFFFF, 32'hFF000000, 32'hFF200000, 32'hFF000000,
                                 32'hFF200000, 32'hFFE00C00, 32'hFFE00C00, 32'hFC000000,
                                 32'hFC000000, 32'hFF000000, 32'hFFE0001F};
    logic [31:0] t_match [11] = '{32'hD503201F, 32'h91000000, 32'h8B000000, 32'hD1000000,
                                  32'hCB000000, 32'hF8400000, 32'hF8000000, 32'h14000000,
                                  32'h94000000, 32'hB4000000, 32'hD4400000};
    opcode_t t_op [11] = '{OPCODE_NOP, OPCODE_ADD, OPCODE_ADD, OPCODE_SUB, OPCODE_SUB,
                           OPCODE_LDUR, OPCODE_STUR, OPCODE_B, OPCODE_BL, OPCODE_CBZ, OPCODE_HLT};

    function automatic opcode_t ref_decode(input logic [31:0] w);
        for (int i = 0; i < 11; i++) begin
            if ((w & t_mask[i]) == t_match[i]) return t_op[i];
        end
        return OPCODE_ERROR;
    endfunction

    function automatic bit m_ready();
        return !m_drain && !m_halted && (mq.size() < 2) && !flush_in;
    endfunction

    // Advance the model by one clock using the currently driven inputs, then step time.
    task automatic tick();
        bit     push;
        bit     pop;
        entry_t e;
        entry_t h;
        push = fetch_valid_in && m_ready();
        pop  = (mq.size() > 0) && dec_ready_in;
        if (pop) begin
            if (m_count < (1 << CW) - 1) m_count++;
            h = mq.pop_front();
            if (h.halt && m_drain && !flush_in) begin
                m_halted = 1'b1;
                m_drain  = 1'b0;
            end
        end
        if (flush_in) begin
            mq.delete();
            m_drain = 1'b0;
        end else if (push) begin
            e.op   = ref_decode(fetch_insn_in);
            e.insn = fetch_insn_in;
            e.pc   = fetch_pc_in;
            e.halt = (e.op == OPCODE_HLT) || (e.op == OPCODE_ERROR);
            mq.push_back(e);
            if (e.halt) m_drain = 1'b1;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input logic [PCW-1:0] pc,
                         input bit fl, input bit rdy);
        fetch_valid_in = v;
        fetch_insn_in  = w;
        fetch_pc_in    = pc;
        flush_in       = fl;
        dec_ready_in   = rdy;
    endtask

    task automatic do_reset();
        rst_N_in = 1'b0;
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_in);
        #1 rst_N_in = 1'b1;
        mq.delete();
        m_drain  = 1'b0;
        m_halted = 1'b0;
        m_count  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_in);
        checks += 7;
        if (dec_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dec_valid_out); end
        if (dec_op_out !== OPCODE_NOP) begin errors++; $display("FAIL reset_op: got %0d expected %0d", dec_op_out, OPCODE_NOP); end
        if (dec_insn_out !== 32'h0) begin errors++; $display("FAIL reset_insn: got %h expected 0", dec_insn_out); end
        if (dec_pc_out !== '0) begin errors++; $display("FAIL reset_pc: got %h expected 0", dec_pc_out); end
        if (halted_out !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted_out); end
        if (decoded_count_out !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", decoded_count_out); end
        if (fetch_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", fetch_ready_out); end
        @(posedge clk_in); #1;
    endtask

    task automatic test_stream();
        logic [31:0] w  [3];
        opcode_t     op [3];
        w  = '{32'h91000421, 32'hF8400020, 32'h14000004};
        op = '{OPCODE_ADD, OPCODE_LDUR, OPCODE_B};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive(1'b1, w[k], 64'h1000 + 64'(4 * k), 1'b0, 1'b1);
            else       drive(1'b0, 32'h0, '0, 1'b0, 1'b1);
            @(negedge clk_in);
            if (k < 3) begin
                checks++;
                if (fetch_ready_out !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", k, fetch_ready_out); end
            end
            checks++;
            if (dec_valid_out !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL stream_valid[%0d]: got %b", k, dec_valid_out); end
            if (k >= 1 && k <= 3) begin
                checks += 2;
                if (dec_op_out !== op[k-1]) begin errors++; $display("FAIL stream_op[%0d]: got %0d expected %0d", k, dec_op_out, op[k-1]); end
                if (dec_pc_out !== 64'h1000 + 64'(4 * (k - 1))) begin errors++; $display("FAIL stream_pc[%0d]: got %h", k, dec_pc_out); end
            end
            tick();
        end
        @(negedge clk_in);
        checks++;
        if (decoded_count_out !== 4'd3) begin errors++; $display("FAIL stream_count: got %0d expected 3", decoded_count_out); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k == 0)      drive(1'b1, 32'h91000421, 64'h1000, 1'b0, 1'b0);
            else if (k == 1) drive(1'b1, 32'hF8400020, 64'h1004, 1'b0, 1'b0);
            else             drive(1'b1, 32'h14000004, 64'h1008, 1'b0, 1'b0);
            @(negedge clk_in);
            if (k >= 2) begin
                checks += 3;
                if (fetch_ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0", k, fetch_ready_out); end
                if (dec_op_out !== OPCODE_ADD) begin errors++; $display("FAIL bp_head_op[%0d]: got %0d expected %0d", k, dec_op_out, OPCODE_ADD); end
                if (dec_pc_out !== 64'h1000) begin errors++; $display("FAIL bp_head_pc[%0d]: got %h expected 1000", k, dec_pc_out); end
            end
            tick();
        end
        drive(1'b0, 32'h0, '0, 1'b0, 1'b1);
        @(negedge clk_in);
        checks += 2;
        if (dec_valid_out !== 1'b1 || dec_op_out !== OPCODE_ADD) begin errors++; $display("FAIL bp_rel0: got v=%b op=%0d expected v=1 op=%0d", dec_valid_out, dec_op_out, OPCODE_ADD); end
        if (dec_pc_out !== 64'h1000) begin errors++; $display("FAIL bp_rel0_pc: got %h expected 1000", dec_pc_out); end
        tick();
        @(negedge clk_in);
        checks += 2;
        if (dec_valid_out !== 1'b1 || dec_op_out !== OPCODE_LDUR) begin errors++; $display("FAIL bp_rel1: got v=%b op=%0d expected v=1 op=%0d", dec_valid_out, dec_op_out, OPCODE_LDUR); end
        if (dec_pc_out !== 64'h1004) begin errors++; $display("FAIL bp_rel1_pc: got %h expected 1004", dec_pc_out); end
        tick();
        @(negedge clk_in);
        checks += 2;
        if (dec_valid_out !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", dec_valid_out); end
        if (decoded_count_out !== 4'd2) begin errors++; $display("FAIL bp_count: got %0d expected 2", decoded_count_out); end
    endtask

    task automatic test_halt_word(input logic [31:0] hw, input opcode_t hop);
        do_reset();
        drive(1'b1, hw, 64'h2000, 1'b0, 1'b0);
        @(negedge clk_in);
        checks++;
        if (fetch_ready_out !== 1'b1) begin errors++; $display("FAIL halt_accept: got %b expected 1", fetch_ready_out); end
        tick();
        drive(1'b1, 32'h91000421, 64'h2004, 1'b0, 1'b0);
        @(negedge clk_in);
        checks += 3;
        if (fetch_ready_out !== 1'b0) begin errors++; $display("FAIL halt_refuse: got %b expected 0", fetch_ready_out); end
        if (dec_valid_out !== 1'b1 || dec_op_out !== hop) begin errors++; $display("FAIL halt_head: got v=%b op=%0d expected v=1 op=%0d", dec_valid_out, dec_op_out, hop); end
        if (halted_out !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halted_out); end
        tick();
        dec_ready_in = 1'b1;
        tick();
        @(negedge clk_in);
        checks += 3;
        if (halted_out !== 1'b1) begin errors++; $display("FAIL halt_state: got %b expected 1", halted_out); end
        if (dec_valid_out !== 1'b0) begin errors++; $display("FAIL halt_empty: got %b expected 0", dec_valid_out); end
        if (decoded_count_out !== 4'd1) begin errors++; $display("FAIL halt_count: got %0d expected 1", decoded_count_out); end
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk_in);
            checks++;
            if (fetch_ready_out !== 1'b0 || halted_out !== 1'b1) begin errors++; $display("FAIL halt_stays[%0d]: got rdy=%b halted=%b expected 0/1", k, fetch_ready_out, halted_out); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'hD503201F, 64'h3000, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, '0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h91000421, 64'h3004, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hD4400000, 64'h3008, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        @(negedge clk_in);
        checks += 2;
        if (fetch_ready_out !== 1'b0) begin errors++; $display("FAIL flush_pre_ready: got %b expected 0", fetch_ready_out); end
        if (dec_op_out !== OPCODE_ADD || dec_pc_out !== 64'h3004) begin errors++; $display("FAIL flush_pre_head: got op=%0d pc=%h expected %0d/3004", dec_op_out, dec_pc_out, OPCODE_ADD); end
        tick();
        drive(1'b1, 32'h91000421, 64'h300C, 1'b1, 1'b0);
        @(negedge clk_in);
        checks++;
        if (fetch_ready_out !== 1'b0) begin errors++; $display("FAIL flush_blocks_push: got %b expected 0", fetch_ready_out); end
        tick();
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        @(negedge clk_in);
        checks += 4;
        if (dec_valid_out !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b expected 0", dec_valid_out); end
        if (halted_out !== 1'b0) begin errors++; $display("FAIL flush_halted: got %b expected 0", halted_out); end
        if (fetch_ready_out !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", fetch_ready_out); end
        if (decoded_count_out !== 4'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", decoded_count_out); end
        drive(1'b1, 32'hF8400020, 64'h3010, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, '0, 1'b0, 1'b1);
        @(negedge clk_in);
        checks++;
        if (dec_valid_out !== 1'b1 || dec_op_out !== OPCODE_LDUR || dec_pc_out !== 64'h3010) begin errors++; $display("FAIL flush_resume: got v=%b op=%0d pc=%h", dec_valid_out, dec_op_out, dec_pc_out); end
        tick();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        drive(1'b1, 32'hD503201F, 64'h4000, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h91000421, 64'h4004, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hD4400000, 64'h4008, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        #2 rst_N_in = 1'b0;
        #1;
        checks += 6;
        if (dec_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", dec_valid_out); end
        if (dec_op_out !== OPCODE_NOP) begin errors++; $display("FAIL midrst_op: got %0d expected %0d", dec_op_out, OPCODE_NOP); end
        if (dec_insn_out !== 32'h0) begin errors++; $display("FAIL midrst_insn: got %h expected 0", dec_insn_out); end
        if (dec_pc_out !== '0) begin errors++; $display("FAIL midrst_pc: got %h expected 0", dec_pc_out); end
        if (halted_out !== 1'b0) begin errors++; $display("FAIL midrst_halted: got %b expected 0", halted_out); end
        if (decoded_count_out !== '0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", decoded_count_out); end
        @(posedge clk_in);
        #1 rst_N_in = 1'b1;
        mq.delete();
        m_drain  = 1'b0;
        m_halted = 1'b0;
        m_count  = 0;
        drive(1'b1, 32'h14000004, 64'h5000, 1'b0, 1'b1);
        @(negedge clk_in);
        checks++;
        if (fetch_ready_out !== 1'b1) begin errors++; $display("FAIL midrst_accept: got %b expected 1", fetch_ready_out); end
        tick();
        drive(1'b0, 32'h0, '0, 1'b0, 1'b1);
        @(negedge clk_in);
        checks++;
        if (dec_valid_out !== 1'b1 || dec_op_out !== OPCODE_B || dec_pc_out !== 64'h5000) begin errors++; $display("FAIL midrst_first: got v=%b op=%0d pc=%h", dec_valid_out, dec_op_out, dec_pc_out); end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'hD503201F, 64'(k), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, '0, 1'b0, 1'b1);
        tick();
        @(negedge clk_in);
        checks++;
        if (decoded_count_out !== 4'hF) begin errors++; $display("FAIL sat_count: got %0d expected 15", decoded_count_out); end
    endtask

    task automatic test_random();
        logic [31:0] pool [9];
        logic [31:0] w;
        int          pick;
        pool = '{32'h91000421, 32'hF8400020, 32'h14000004, 32'hD1000421, 32'h8B020020,
                 32'hF8000020, 32'h94000010, 32'hB4000040, 32'hD503201F};
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            pick = $urandom_range(0, 31);
            if (pick == 0)      w = 32'hD4400000;
            else if (pick == 1) w = $urandom;
            else if (pick < 8)  w = pool[$urandom_range(0, 8)] ^ ($urandom & 32'h0000_03FF);
            else                w = pool[$urandom_range(0, 8)];
            drive($urandom_range(0, 9) < 8, w, {$urandom, $urandom},
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7);
            @(negedge clk_in);
            checks += 4;
            if (fetch_ready_out !== m_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, fetch_ready_out, m_ready()); end
            if (dec_valid_out !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, dec_valid_out, mq.size() != 0); end
            if (halted_out !== m_halted) begin errors++; $display("FAIL rand_halted[%0d]: got %b expected %b", c, halted_out, m_halted); end
            if (decoded_count_out !== CW'(m_count)) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", c, decoded_count_out, m_count); end
            if (mq.size() != 0) begin
                checks++;
                if (dec_op_out !== mq[0].op || dec_insn_out !== mq[0].insn || dec_pc_out !== mq[0].pc) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: got op=%0d insn=%h pc=%h expected op=%0d insn=%h pc=%h",
                             c, dec_op_out, dec_insn_out, dec_pc_out, mq[0].op, mq[0].insn, mq[0].pc);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_N_in = 1'b0;
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
        test_reset();
        test_stream();
        test_backpressure();
        test_halt_word(32'hD4400000, OPCODE_HLT);
        test_halt_word(32'hFFFFFFFF, OPCODE_ERROR);
        test_flush();
        test_reset_midstream();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
